// File: rtl/alu_module.sv
// Clocked 32-bit ALU for the KGP-RISC datapath: shifts, AND, XOR, add, bit-difference
// position and two's complement, with a registered result and registered status flags.
module alu_module (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  ShiftAmount,
    input  logic [3:0]  ALUOps,
    output logic [31:0] Output,
    output logic        Carry_Out,
    output logic        FlagZero,
    output logic        FlagSign,
    output logic        FlagEqual
);

    typedef enum logic [3:0] {
        OpShll  = 4'b0000,
        OpShrl  = 4'b0001,
        OpShra  = 4'b0010,
        OpShrav = 4'b0011,
        OpShllv = 4'b0100,
        OpShrlv = 4'b0101,
        OpAnd   = 4'b1000,
        OpXor   = 4'b1001,
        OpAdd   = 4'b1010,
        OpDiff  = 4'b1011,
        OpComp  = 4'b1111
    } alu_op_e;

    logic [31:0] result_d;
    logic        carry_d;
    logic [32:0] sum;
    logic [31:0] diff_bits;
    logic [5:0]  diff_idx;
    logic [4:0]  var_amt;

    assign sum       = {1'b0, A} + {1'b0, B};
    assign diff_bits = A ^ B;
    assign var_amt   = B[4:0];

    // Lowest set bit of A ^ B; scanning downward lets the lowest index win, 32 when equal.
    always_comb begin
        diff_idx = 6'd32;
        for (int i = 31; i >= 0; i--) begin
            if (diff_bits[i]) begin
                diff_idx = 6'(i);
            end
        end
    end

    // Operation decode producing the next result and carry.
    always_comb begin
        result_d = 32'd0;
        carry_d  = 1'b0;
        case (alu_op_e'(ALUOps))
            OpShll:  result_d = A << ShiftAmount;
            OpShllv: result_d = A << var_amt;
            OpShrl:  result_d = A >> ShiftAmount;
            OpShrlv: result_d = A >> var_amt;
            OpShra:  result_d = $signed(A) >>> ShiftAmount;
            OpShrav: result_d = $signed(A) >>> var_amt;
            OpAnd:   result_d = A & B;
            OpXor:   result_d = A ^ B;
            OpAdd: begin
                result_d = sum[31:0];
                carry_d  = sum[32];
            end
            OpDiff:  result_d = {26'd0, diff_idx};
            OpComp:  result_d = ~B + 32'd1;
            default: begin
                result_d = 32'd0;
                carry_d  = 1'b0;
            end
        endcase
    end

    // Result and flag registers; synchronous active-low reset takes priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            Output    <= 32'd0;
            Carry_Out <= 1'b0;
            FlagZero  <= 1'b1;
            FlagSign  <= 1'b0;
            FlagEqual <= 1'b0;
        end else begin
            Output    <= result_d;
            Carry_Out <= carry_d;
            FlagZero  <= (result_d == 32'd0);
            FlagSign  <= result_d[31];
            FlagEqual <= (A == B);
        end
    end

endmodule

// File: tb/tb_alu_module.sv
// Self-checking bench for alu_module: directed steps, expected values queued when driven
// and popped when the registered outputs are sampled one edge later.
module tb_alu_module;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  ShiftAmount;
    logic [3:0]  ALUOps;
    logic [31:0] Output;
    logic        Carry_Out;
    logic        FlagZero;
    logic        FlagSign;
    logic        FlagEqual;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        s;
        logic        e;
    } exp_t;

    exp_t sb[$];

    alu_module dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .ShiftAmount(ShiftAmount),
        .ALUOps     (ALUOps),
        .Output     (Output),
        .Carry_Out  (Carry_Out),
        .FlagZero   (FlagZero),
        .FlagSign   (FlagSign),
        .FlagEqual  (FlagEqual)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    // Pop the oldest expectation and compare it with the sampled outputs.
    task automatic check_out();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard: observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (Output === e.res) else begin
            errors++;
            $error("FAIL %s.Output: observed=0x%08h expected=0x%08h", e.tag, Output, e.res);
        end
        check_bit({e.tag, ".Carry_Out"}, Carry_Out, e.c);
        check_bit({e.tag, ".FlagZero"}, FlagZero, e.z);
        check_bit({e.tag, ".FlagSign"}, FlagSign, e.s);
        check_bit({e.tag, ".FlagEqual"}, FlagEqual, e.e);
    endtask

    // One cycle: drive at the falling edge, queue the expectation, sample 1 unit after the
    // rising edge. When rstv is 0 the expectation is the reset state.
    task automatic step(input string tag, input logic rstv, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] exp_res, input logic exp_c);
        exp_t e;
        @(negedge clk);
        rst         = rstv;
        ALUOps      = op;
        A           = a;
        B           = b;
        ShiftAmount = sh;
        e.tag = tag;
        if (!rstv) begin
            e.res = 32'd0;
            e.c   = 1'b0;
            e.z   = 1'b1;
            e.s   = 1'b0;
            e.e   = 1'b0;
        end else begin
            e.res = exp_res;
            e.c   = exp_c;
            e.z   = (exp_res == 32'd0);
            e.s   = exp_res[31];
            e.e   = (a == b);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [32:0] rsum;

        rst         = 1'b0;
        A           = 32'd0;
        B           = 32'd0;
        ShiftAmount = 5'd0;
        ALUOps      = 4'b0000;

        // Reset with operands that would otherwise give a nonzero result and FlagEqual=1.
        step("reset0", 1'b0, 4'b1010, 32'h8000_0001, 32'h8000_0001, 5'd3, 32'd0, 1'b0);
        step("reset1", 1'b0, 4'b1111, 32'd5, 32'd5, 5'd1, 32'd0, 1'b0);

        // Shifts.
        step("shll",  1'b1, 4'b0000, 32'd234, 32'd3, 5'd2, 32'd936, 1'b0);
        step("shrl",  1'b1, 4'b0001, 32'd234, 32'd3, 5'd2, 32'd58, 1'b0);
        step("shra",  1'b1, 4'b0010, 32'd234, 32'd3, 5'd2, 32'd58, 1'b0);
        step("shllv", 1'b1, 4'b0100, 32'd234, 32'd3, 5'd2, 32'd1872, 1'b0);
        step("shrlv", 1'b1, 4'b0101, 32'd234, 32'd3, 5'd2, 32'd29, 1'b0);
        step("shrav", 1'b1, 4'b0011, 32'd234, 32'd3, 5'd2, 32'd29, 1'b0);
        step("shra_neg", 1'b1, 4'b0010, 32'h8000_0000, 32'd0, 5'd4, 32'hF800_0000, 1'b0);
        step("shrav_neg", 1'b1, 4'b0011, 32'h8000_0000, 32'hFFFF_FFE4, 5'd0, 32'hF800_0000,
             1'b0);
        step("shrlv_hi", 1'b1, 4'b0101, 32'h8000_0000, 32'hFFFF_FFE4, 5'd0, 32'h0800_0000, 1'b0);
        step("shllv_0", 1'b1, 4'b0100, 32'h1234_5678, 32'hFFFF_FFE0, 5'd7, 32'h1234_5678, 1'b0);

        // Logic and add.
        step("and", 1'b1, 4'b1000, 32'd234, 32'd523, 5'd0, 32'd10, 1'b0);
        step("xor", 1'b1, 4'b1001, 32'd234, 32'd523, 5'd0, 32'd737, 1'b0);
        step("add", 1'b1, 4'b1010, 32'd234, 32'd523, 5'd0, 32'd757, 1'b0);
        step("add_carry", 1'b1, 4'b1010, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b1);

        // diff.
        step("diff_4_16", 1'b1, 4'b1011, 32'd4, 32'd16, 5'd0, 32'd2, 1'b0);
        step("diff_eq",   1'b1, 4'b1011, 32'd7, 32'd7, 5'd0, 32'd32, 1'b0);
        step("diff_msb",  1'b1, 4'b1011, 32'd0, 32'h8000_0000, 5'd0, 32'd31, 1'b0);

        // comp.
        step("comp_523", 1'b1, 4'b1111, 32'd99, 32'd523, 5'd0, 32'hFFFF_FDF5, 1'b0);
        step("comp_1",   1'b1, 4'b1111, 32'd0, 32'd1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        step("comp_0",   1'b1, 4'b1111, 32'd7, 32'd0, 5'd0, 32'd0, 1'b0);

        // Undefined codes.
        step("undef_1100", 1'b1, 4'b1100, 32'd234, 32'd523, 5'd2, 32'd0, 1'b0);
        step("undef_0110", 1'b1, 4'b0110, 32'hFFFF_FFFF, 32'd1, 5'd2, 32'd0, 1'b0);

        // Back-to-back stream with reset in the middle, then recovery.
        step("seq_add",   1'b1, 4'b1010, 32'd100, 32'd23, 5'd0, 32'd123, 1'b0);
        step("seq_rst",   1'b0, 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b0);
        step("seq_first", 1'b1, 4'b1001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'hFF00_FF00,
             1'b0);
        step("seq_shll",  1'b1, 4'b0000, 32'h0000_0001, 32'd9, 5'd31, 32'h8000_0000, 1'b0);

        // Random add/xor pairs against a 33-bit reference sum.
        for (int i = 0; i < 8; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rsum = {1'b0, ra} + {1'b0, rb};
            step($sformatf("rnd_add%0d", i), 1'b1, 4'b1010, ra, rb, 5'd0, rsum[31:0], rsum[32]);
            step($sformatf("rnd_xor%0d", i), 1'b1, 4'b1001, ra, rb, 5'd0, ra ^ rb, 1'b0);
        end

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_module.md
# alu_module

Clocked 32-bit ALU for the KGP-RISC datapath, sitting between the register-file read ports and the writeback mux. Performs shifts (immediate- and register-amount), AND, XOR, add, bit-difference position and two's complement. Results and status flags are registered. The branch unit consumes the flags and the writeback stage consumes the result.

## Interface
- No parameters; data width fixed at 32.
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-low.
- A  input  32  operand A (rs value).
- B  input  32  operand B (rt value or sign-extended immediate).
- ShiftAmount  input  5  immediate shift amount for shll/shrl/shra.
- ALUOps  input  4  operation select.
- Output  output  32  registered result.
- Carry_Out  output  1  registered carry out of bit 31 for add; 0 for all other ops.
- FlagZero  output  1  registered, (Output == 0).
- FlagSign  output  1  registered, Output[31].
- FlagEqual  output  1  registered, (A == B) for the operands sampled that cycle.

## Operation
ALUOps encoding; all arithmetic is modulo 2^32:
- 0000 shll: A << ShiftAmount; zero fill.
- 0100 shllv: A << B[4:0]; zero fill.
- 0001 shrl: A >> ShiftAmount; logical, zero fill.
- 0101 shrlv: A >> B[4:0]; logical, zero fill.
- 0010 shra: A >>> ShiftAmount; arithmetic, replicate A[31].
- 0011 shrav: A >>> B[4:0]; arithmetic, replicate A[31].
- 1000 and: A & B.
- 1001 xor: A ^ B.
- 1010 add (also addi, lw/sw address): A + B.
  - Carry_Out = bit 32 of the 33-bit sum.
- 1011 diff: index (0..31) of the least-significant bit where A and B differ, i.e. lowest set bit of A ^ B.
  - If A == B, result is 32.
- 1111 comp/compi: two's complement of B, (~B + 1); A is ignored.
  - comp of 0 gives 0.
- All other codes (0110, 0111, 1100, 1101, 1110): Output = 0, Carry_Out = 0.
- For variable shifts, B[31:5] is ignored; shift by 0 passes A unchanged.
- Flags are computed from the newly computed result (and current A/B for FlagEqual), not from the previous register contents.

## Timing
- Reset (rst == 0 at a rising edge):
  - Output = 0, Carry_Out = 0, FlagSign = 0, FlagEqual = 0.
  - FlagZero = 1, consistent with Output = 0.
  - Reset has priority over any operation in the same cycle.
- Latency is 1 cycle: inputs sampled at rising edge N appear on all outputs after edge N and are held until edge N+1.
- There is no enable or handshake: a new operation is accepted every cycle, with full throughput.
- Outputs are purely registered, with no combinational path from inputs to outputs.
- Reset asserted mid-stream discards the in-flight result.
- The first valid result appears one edge after rst returns high with operands applied.

## Test plan
- Reset: hold rst=0 for 2 edges with arbitrary inputs -> Output=0, Carry_Out=0, FlagZero=1, FlagSign=0, FlagEqual=0.
- Shifts with A=234, ShiftAmount=2:
  - shll -> 936; shrl -> 58; shra -> 58.
  - With B=3: shllv -> 1872; shrlv -> 29; shrav -> 29.
  - A=0x80000000, shra by 4 -> 0xF8000000 with FlagSign=1.
- Logic and add with A=234, B=523:
  - and -> 10; xor -> 737; add -> 757 with Carry_Out=0.
  - A=0xFFFFFFFF, B=1, add -> Output=0, Carry_Out=1, FlagZero=1.
- diff:
  - A=4, B=16 -> 2.
  - A=B=7 -> 32 with FlagEqual=1.
  - A=0, B=0x80000000 -> 31.
- comp:
  - B=523 -> 0xFFFFFDF5 with FlagSign=1.
  - B=1 -> 0xFFFFFFFF.
  - B=0 -> 0 with FlagZero=1.
- Pipelining and edge cases:
  - Back-to-back ops on consecutive cycles each appear exactly one edge later.
  - Assert rst in the middle of the sequence -> outputs go to reset values on that edge.
  - An undefined code (e.g. 1100) -> Output=0.
